// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch/data request ports and the memory macro port.
// slave = arbiter side, master = stages/memory side.
interface mem_port_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              halt;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_stall;
  logic              i_done;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_stall;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  halt,
    input  i_req,
    input  i_addr,
    output i_stall,
    output i_done,
    output i_rdata,
    input  d_req,
    input  d_wr,
    input  d_addr,
    input  d_wdata,
    output d_stall,
    output d_done,
    output d_rdata,
    output mem_en,
    output mem_wr,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport master (
    output halt,
    output i_req,
    output i_addr,
    input  i_stall,
    input  i_done,
    input  i_rdata,
    output d_req,
    output d_wr,
    output d_addr,
    output d_wdata,
    input  d_stall,
    input  d_done,
    input  d_rdata,
    input  mem_en,
    input  mem_wr,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// I/D arbiter for a single fixed-latency memory port.
// MEM_ARB_RR_EN selects round-robin; default is fixed D-over-I priority.
module mem_port_arbiter #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus,
  output logic              busy
);
  localparam int CW = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_n;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic i_ok;
  logic d_ok;
  logic pick_d;
  logic issue;
  logic i_done;
  logic d_done;

  assign i_ok  = bus.i_req && !bus.halt;
  assign d_ok  = bus.d_req;
  assign issue = (state == IDLE)
              && (i_ok || d_ok);

`ifdef MEM_ARB_RR_EN
  logic last_d;

  assign pick_d = d_ok
               && (!i_ok || !last_d);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_d <= 1'b0;
    end else if (issue) begin
      last_d <= pick_d;
    end
  end
`else
  assign pick_d = d_ok;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    i_done  = 1'b0;
    d_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (issue) begin
          cnt_n   = CW'(MEM_LAT - 1);
          state_n = pick_d ? BUSY_D
                           : BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (cnt == '0) begin
          i_done  = (state == BUSY_I);
          d_done  = (state == BUSY_D);
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      wr_q   <= 1'b0;
    end else if (issue) begin
      addr_q <= pick_d ? bus.d_addr
                       : bus.i_addr;
      wr_q   <= pick_d && bus.d_wr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (i_done) begin
        i_rdata_q <= bus.mem_rdata;
      end
      if (d_done && !wr_q) begin
        d_rdata_q <= bus.mem_rdata;
      end
    end
  end

  // Issue is combinational, so reset must mask the strobe directly.
  assign bus.mem_en    = issue && rst;
  assign bus.mem_wr    = bus.mem_en
                      && pick_d
                      && bus.d_wr;
  assign bus.mem_addr  = !issue ? addr_q
                       : pick_d ? bus.d_addr
                                : bus.i_addr;
  assign bus.mem_wdata = bus.d_wdata;

  assign bus.i_done  = i_done;
  assign bus.d_done  = d_done;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.i_stall = bus.i_req && !i_done;
  assign bus.d_stall = bus.d_req && !d_done;

  assign busy = (state != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a fixed-latency memory model.
// Directed scenarios push expected issue/done events; a monitor pops them.
module tb_mem_port_arbiter;
  localparam int DW  = 16;
  localparam int AW  = 16;
  localparam int LAT = 2;

  localparam int K_ISS = 0;
  localparam int K_DI  = 1;
  localparam int K_DD  = 2;

  typedef struct {
    int        kind;
    int        cyc;
    logic [15:0] addr;
    logic      wr;
    logic [15:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  q[$];

  logic        pend_i = 1'b0;
  logic        pend_d = 1'b0;
  logic [15:0] pend_i_val;
  logic [15:0] pend_d_val;

  mem_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

  mem_port_arbiter #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .MEM_LAT(LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .busy(busy)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory model: issue sampled mid-cycle, data returned LAT cycles later.
  logic [15:0] mem [256];
  logic [15:0] pipe [LAT];
  logic        iss;
  logic        iss_wr;
  logic [7:0]  iss_a;
  logic [15:0] iss_wd;

  assign bus.mem_rdata = pipe[LAT-1];

  always @(negedge clk) begin
    iss    <= bus.mem_en;
    iss_wr <= bus.mem_wr;
    iss_a  <= bus.mem_addr[7:0];
    iss_wd <= bus.mem_wdata;
  end

  always @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 256; k++) mem[k] <= 16'(k);
      mem[8'h10] <= 16'hABCD;
      mem[8'h20] <= 16'h2222;
      mem[8'h30] <= 16'h3333;
      mem[8'h50] <= 16'h5555;
      for (int k = 0; k < LAT; k++) pipe[k] <= 16'hDEAD;
    end else begin
      if (iss && iss_wr) mem[iss_a] <= iss_wd;
      pipe[0] <= (iss && !iss_wr) ? mem[iss_a] : 16'hDEAD;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cyc %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic push_iss(input int c, input logic [15:0] a,
                          input logic w, input logic [15:0] wd);
    ev_t e;
    e.kind = K_ISS; e.cyc = c; e.addr = a; e.wr = w; e.data = wd;
    q.push_back(e);
  endtask

  task automatic push_done(input int k, input int c,
                           input logic [15:0] rd);
    ev_t e;
    e.kind = k; e.cyc = c; e.addr = '0; e.wr = 1'b0; e.data = rd;
    q.push_back(e);
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial forever begin
    int  k;
    ev_t e;
    @(negedge clk);
    if (rst) begin
      if (pend_i) begin
        chk("i_rdata", 32'(bus.i_rdata), 32'(pend_i_val));
        pend_i = 1'b0;
      end
      if (pend_d) begin
        chk("d_rdata", 32'(bus.d_rdata), 32'(pend_d_val));
        pend_d = 1'b0;
      end
      if (bus.mem_en || bus.i_done || bus.d_done) begin
        k = bus.mem_en ? K_ISS : bus.i_done ? K_DI : K_DD;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got kind %0d expected none (cyc %0d)",
                   k, cyc);
        end else begin
          e = q.pop_front();
          chk("event_kind", 32'(k), 32'(e.kind));
          chk("event_cycle", 32'(cyc), 32'(e.cyc));
          if (k == K_ISS) begin
            chk("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
            chk("mem_wr", 32'(bus.mem_wr), 32'(e.wr));
            if (e.wr) chk("mem_wdata", 32'(bus.mem_wdata), 32'(e.data));
          end else if (k == K_DI) begin
            pend_i = 1'b1;
            pend_i_val = e.data;
          end else begin
            pend_d = 1'b1;
            pend_d_val = e.data;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    bus.halt = 1'b0;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_wr = 1'b0;
    bus.d_addr = '0; bus.d_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    bus.i_req = 1'b1; bus.i_addr = 16'h0010;
    #1;
    chk("rst_mem_en", 32'(bus.mem_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_i_done", 32'(bus.i_done), 0);
    chk("rst_i_rdata", 32'(bus.i_rdata), 0);
    chk("rst_d_rdata", 32'(bus.d_rdata), 0);
    bus.i_req = 1'b0;
    rst = 1'b1;
    goto(cyc + 1);

    // single fetch
    c = cyc;
    push_iss(c, 16'h0010, 1'b0, 16'h0);
    push_done(K_DI, c + 2, 16'hABCD);
    bus.i_req = 1'b1; bus.i_addr = 16'h0010;
    #1;
    chk("t1_i_stall_c0", 32'(bus.i_stall), 1);
    goto(c + 1);
    chk("t1_i_stall_c1", 32'(bus.i_stall), 1);
    chk("t1_busy", 32'(busy), 1);
    goto(c + 2);
    chk("t1_i_stall_c2", 32'(bus.i_stall), 0);
    goto(c + 3);
    bus.i_req = 1'b0;

    // simultaneous fetch and load
    c = cyc;
    push_iss(c, 16'h0020, 1'b0, 16'h0);
    push_done(K_DD, c + 2, 16'h2222);
    push_iss(c + 3, 16'h0030, 1'b0, 16'h0);
    push_done(K_DI, c + 5, 16'h3333);
    bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 16'h0020;
    bus.i_req = 1'b1; bus.i_addr = 16'h0030;
    goto(c + 3);
    bus.d_req = 1'b0;
    goto(c + 6);
    bus.i_req = 1'b0;

    // store leaves d_rdata alone
    c = cyc;
    push_iss(c, 16'h0040, 1'b1, 16'h1234);
    push_done(K_DD, c + 2, 16'h2222);
    bus.d_req = 1'b1; bus.d_wr = 1'b1;
    bus.d_addr = 16'h0040; bus.d_wdata = 16'h1234;
    goto(c + 3);
    bus.d_req = 1'b0; bus.d_wr = 1'b0;

    // read back the stored word
    c = cyc;
    push_iss(c, 16'h0040, 1'b0, 16'h0);
    push_done(K_DD, c + 2, 16'h1234);
    bus.d_req = 1'b1; bus.d_addr = 16'h0040;
    goto(c + 3);
    bus.d_req = 1'b0;

    // async reset in the middle of a fetch
    c = cyc;
    push_iss(c, 16'h0010, 1'b0, 16'h0);
    bus.i_req = 1'b1; bus.i_addr = 16'h0010;
    goto(c + 1);
    rst = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_mem_en", 32'(bus.mem_en), 0);
    chk("t5_i_done", 32'(bus.i_done), 0);
    chk("t5_i_rdata", 32'(bus.i_rdata), 0);
    chk("t5_d_rdata", 32'(bus.d_rdata), 0);
    rst = 1'b1;
    push_iss(c + 1, 16'h0010, 1'b0, 16'h0);
    push_done(K_DI, c + 3, 16'hABCD);
    goto(c + 4);
    bus.i_req = 1'b0;

    // both held for four accesses
    c = cyc;
`ifdef MEM_ARB_RR_EN
    push_iss(c, 16'h0020, 1'b0, 16'h0);
    push_done(K_DD, c + 2, 16'h2222);
    push_iss(c + 3, 16'h0010, 1'b0, 16'h0);
    push_done(K_DI, c + 5, 16'hABCD);
    push_iss(c + 6, 16'h0020, 1'b0, 16'h0);
    push_done(K_DD, c + 8, 16'h2222);
    push_iss(c + 9, 16'h0010, 1'b0, 16'h0);
    push_done(K_DI, c + 11, 16'hABCD);
`else
    for (int n = 0; n < 4; n++) begin
      push_iss(c + 3 * n, 16'h0020, 1'b0, 16'h0);
      push_done(K_DD, c + 3 * n + 2, 16'h2222);
    end
`endif
    bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 16'h0020;
    bus.i_req = 1'b1; bus.i_addr = 16'h0010;
    goto(c + 12);
    bus.d_req = 1'b0;
    bus.i_req = 1'b0;

    // halt blocks fetch, load still served
    c = cyc;
    bus.halt = 1'b1;
    bus.i_req = 1'b1; bus.i_addr = 16'h0010;
    goto(c + 2);
    push_iss(c + 2, 16'h0050, 1'b0, 16'h0);
    push_done(K_DD, c + 4, 16'h5555);
    bus.d_req = 1'b1; bus.d_addr = 16'h0050;
    goto(c + 4);
    chk("t6_i_stall", 32'(bus.i_stall), 1);
    goto(c + 5);
    bus.d_req = 1'b0;
    bus.i_req = 1'b0;
    bus.halt = 1'b0;

    goto(cyc + 3);
    chk("queue_empty", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
